// File: rtl/writeback_buffer_if.sv
// rtl/writeback_buffer_if.sv - eviction push, refill lookup and RAM write signals of the writeback buffer
interface writeback_buffer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] lk_addr;
    logic              lk_hit;
    logic [DATA_W-1:0] lk_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_ack;

    modport master (
        output wb_valid, wb_addr, wb_data, lk_addr, ram_ack,
        input  wb_ready, lk_hit, lk_data, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, lk_addr, ram_ack,
        output wb_ready, lk_hit, lk_data, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/writeback_buffer.sv
// rtl/writeback_buffer.sv - coalescing in-order writeback FIFO with refill forwarding
module writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    writeback_buffer_if.slave        bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_RETIRE = 2'd2;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [1:0]        state;

    logic              co_hit;
    logic [PW-1:0]     co_idx;
    logic              push;
    logic              alloc;
    logic              ack;
    logic [PW-1:0]     lk_idx;

    assign bus.wb_ready = (count < CW'(DEPTH));
    assign empty        = (count == '0);
    assign push         = bus.wb_valid & bus.wb_ready;
    assign alloc        = push & ~co_hit;
    assign ack          = (state == S_ISSUE) & bus.ram_ack;

    // The head is frozen while its write is on the RAM bus, so it never absorbs a coalesce.
    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_q[i] == bus.wb_addr &&
                !(state == S_ISSUE && PW'(i) == head)) begin
                co_hit = 1'b1;
                co_idx = PW'(i);
            end
        end
    end

    // Walk oldest to youngest so the last match found is the youngest.
    always_comb begin
        bus.lk_hit  = 1'b0;
        bus.lk_data = '0;
        lk_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            lk_idx = head + PW'(k);
            if (valid_q[lk_idx] && addr_q[lk_idx] == bus.lk_addr) begin
                bus.lk_hit  = 1'b1;
                bus.lk_data = data_q[lk_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            if (co_hit) begin
                data_q[co_idx] <= bus.wb_data;
            end else begin
                addr_q[tail] <= bus.wb_addr;
                data_q[tail] <= bus.wb_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (ack) begin
                valid_q[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (alloc) begin
                valid_q[tail] <= 1'b1;
                tail          <= tail + 1'b1;
            end
            count <= count + CW'(alloc) - CW'(ack);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        bus.ram_addr <= addr_q[head];
                        // A coalesce into the head on the latch edge must not be lost.
                        bus.ram_wdata <= (push && co_hit && co_idx == head) ?
                                         bus.wb_data : data_q[head];
                        bus.ram_we   <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.ram_ack) begin
                        bus.ram_we <= 1'b0;
                        state      <= S_RETIRE;
                    end
                end
                S_RETIRE: state <= S_IDLE;
                default: begin
                    bus.ram_we <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_writeback_buffer.sv
// tb/tb_writeback_buffer.sv - directed self-checking bench for writeback_buffer
module tb_writeback_buffer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] count;
    logic       empty;
    int         checks = 0;
    int         errors = 0;

    writeback_buffer_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    writeback_buffer #(.DEPTH(4), .ADDR_W(12), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .count (count),
        .empty (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] a, input logic [31:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
        bus.wb_data  = d;
        tick();
        bus.wb_valid = 1'b0;
    endtask

    task automatic look(input logic [11:0] a);
        bus.lk_addr = a;
        #1;
    endtask

    task automatic wait_we(output int n);
        n = 0;
        while (bus.ram_we !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("ram_we_timeout", {31'd0, bus.ram_we}, 32'd1);
    endtask

    task automatic drain_one(input logic [11:0] a, input logic [31:0] d, input string tag);
        int n;
        wait_we(n);
        chk({tag, "_addr"}, {20'd0, bus.ram_addr}, {20'd0, a});
        chk({tag, "_data"}, bus.ram_wdata, d);
        bus.ram_ack = 1'b1;
        tick();
        bus.ram_ack = 1'b0;
    endtask

    initial begin
        int n;
        logic seen;
        rst_n        = 1'b0;
        bus.wb_valid = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        bus.lk_addr  = '0;
        bus.ram_ack  = 1'b0;
        #12;
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_ready", {31'd0, bus.wb_ready}, 32'd1);
        chk("rst_we", {31'd0, bus.ram_we}, 32'd0);
        chk("rst_addr", {20'd0, bus.ram_addr}, 32'd0);
        rst_n = 1'b1;
        tick();

        // single write with prompt ack
        push(12'hBDC, 32'h2B1);
        chk("t1_count1", {29'd0, count}, 32'd1);
        chk("t1_we_late", {31'd0, bus.ram_we}, 32'd0);
        tick();
        chk("t1_we", {31'd0, bus.ram_we}, 32'd1);
        drain_one(12'hBDC, 32'h2B1, "t1");
        chk("t1_count0", {29'd0, count}, 32'd0);
        chk("t1_empty", {31'd0, empty}, 32'd1);
        chk("t1_we_drop", {31'd0, bus.ram_we}, 32'd0);
        tick();

        // fill to full with RAM stalled, then drain in order
        for (int i = 1; i <= 4; i++) push(12'(i * 16), i);
        chk("t2_count4", {29'd0, count}, 32'd4);
        chk("t2_ready0", {31'd0, bus.wb_ready}, 32'd0);
        push(12'h050, 32'd5);
        chk("t2_count_still4", {29'd0, count}, 32'd4);
        look(12'h050);
        chk("t2_fifth_absent", {31'd0, bus.lk_hit}, 32'd0);
        chk("t2_addr_stable", {20'd0, bus.ram_addr}, 32'h010);
        chk("t2_we_held", {31'd0, bus.ram_we}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) begin
                wait_we(n);
                chk("t2_spacing", n, 32'd2);
            end
            drain_one(12'(i * 16), i, "t2");
        end
        chk("t2_empty", {31'd0, empty}, 32'd1);
        tick();

        // coalescing around a locked head
        push(12'h010, 32'h1);
        tick();
        chk("t3_locked", {31'd0, bus.ram_we}, 32'd1);
        push(12'h020, 32'hA);
        push(12'h020, 32'hB);
        chk("t3_count2", {29'd0, count}, 32'd2);
        look(12'h020);
        chk("t3_lk020", bus.lk_data, 32'hB);
        push(12'h010, 32'hC);
        chk("t3_count3", {29'd0, count}, 32'd3);
        look(12'h010);
        chk("t3_lk010", bus.lk_data, 32'hC);
        chk("t3_wdata_frozen", bus.ram_wdata, 32'h1);
        drain_one(12'h010, 32'h1, "t3a");
        drain_one(12'h020, 32'hB, "t3b");
        drain_one(12'h010, 32'hC, "t3c");
        chk("t3_count0", {29'd0, count}, 32'd0);
        tick();

        // lookup hit and miss
        push(12'h3C0, 32'h55);
        look(12'h3C0);
        chk("t4_hit", {31'd0, bus.lk_hit}, 32'd1);
        chk("t4_data", bus.lk_data, 32'h55);
        look(12'h3C1);
        chk("t4_miss", {31'd0, bus.lk_hit}, 32'd0);
        chk("t4_miss_data", bus.lk_data, 32'd0);
        drain_one(12'h3C0, 32'h55, "t4");
        look(12'h3C0);
        chk("t4_retired", {31'd0, bus.lk_hit}, 32'd0);
        tick();

        // push racing an ack
        for (int i = 0; i < 4; i++) push(12'h100 + 12'(i), 32'h100 + i);
        chk("t5_full", {29'd0, count}, 32'd4);
        bus.ram_ack = 1'b1;
        push(12'h104, 32'h104);
        bus.ram_ack = 1'b0;
        chk("t5_rej_count", {29'd0, count}, 32'd3);
        look(12'h104);
        chk("t5_rej_absent", {31'd0, bus.lk_hit}, 32'd0);
        wait_we(n);
        chk("t5_next_addr", {20'd0, bus.ram_addr}, 32'h101);
        bus.ram_ack = 1'b1;
        push(12'h105, 32'h5);
        bus.ram_ack = 1'b0;
        chk("t5_acc_count", {29'd0, count}, 32'd3);
        look(12'h105);
        chk("t5_acc_hit", {31'd0, bus.lk_hit}, 32'd1);

        // asynchronous reset in the middle of a write
        wait_we(n);
        chk("t6_pre_count", {29'd0, count}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_we_async", {31'd0, bus.ram_we}, 32'd0);
        chk("t6_count_async", {29'd0, count}, 32'd0);
        chk("t6_empty", {31'd0, empty}, 32'd1);
        #10;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | bus.ram_we;
        end
        chk("t6_no_write", {31'd0, seen}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
